ppg_beat_detect: RTL and testbench

Downstream consumer of the AFE4403 SPI readout stage. Takes each ambient-corrected 24-bit PPG sample (LED2−ALED2) on the readout-done strobe and applies a moving-average smoother and a first-order DC baseline remover. It then detects heartbeats with a threshold/refractory state machine and reports the inter-beat interval (IBI) in sample periods, plus a no-signal flag.

---
 rtl/ppg_pkg.sv | 13 +
 rtl/ppg_mov_avg.sv | 40 ++++
 rtl/ppg_beat_detect.sv | 120 ++++++++++++
 tb/tb_ppg_beat_detect.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// ppg_pkg: shared widths, saturation limits, FSM state codes and a clamp helper for the PPG beat detector
package ppg_pkg;
    localparam int SMP_W = 24;
    localparam logic signed [SMP_W-1:0] SMP_MAX = 24'sh7FFFFF;
    localparam logic signed [SMP_W-1:0] SMP_MIN = -SMP_MAX;
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_PEAK = 2'd1;
    localparam logic [1:0] S_REFR = 2'd2;
    // Clamp a one-bit-wider signed value to the symmetric sample range.
    function automatic logic signed [SMP_W-1:0] sat(input logic signed [SMP_W:0] x);
        return (x > SMP_MAX) ? SMP_MAX : (x < SMP_MIN) ? SMP_MIN : SMP_W'(x);
    endfunction
endpackage

// File: rtl/ppg_mov_avg.sv
// ppg_mov_avg: 2^AVG_LOG2-tap moving average over a circular buffer, one cycle latency
//   clk, rst (sync, active-low) | smp_vld_i, smp_i: sample strobe/data | filt_vld_o, filt_o: averaged output
module ppg_mov_avg
    import ppg_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    smp_vld_i,
    input  logic signed [SMP_W-1:0] smp_i,
    output logic signed [SMP_W-1:0] filt_o,
    output logic                    filt_vld_o
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW = SMP_W + AVG_LOG2;
    logic signed [SMP_W-1:0] mem_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;
    logic signed [SW-1:0] sum_q, sum_d;
    logic vld_q;
    // Oldest word leaves the window as the new one enters; a cleared buffer yields zero-filled partial averages.
    assign sum_d = sum_q + SW'(smp_i) - SW'(mem_q[ptr_q]);
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            sum_q <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            vld_q <= smp_vld_i;
            if (smp_vld_i) begin
                mem_q[ptr_q] <= smp_i;
                ptr_q <= ptr_q + AVG_LOG2'(1);
                sum_q <= sum_d;
            end
        end
    end
    assign filt_o = SMP_W'(sum_q >>> AVG_LOG2);
    assign filt_vld_o = vld_q;
endmodule

// File: rtl/ppg_beat_detect.sv
// ppg_beat_detect: PPG smoother, baseline remover and threshold/refractory beat detector with IBI output
//   clk, rst (sync, active-low) | sample_vld, sample_in: input samples
//   filt_out/filt_vld: moving average | ac_out: baseline-removed signal | beat_pulse, ibi/ibi_vld, no_signal
//   Build option PPG_INVERT_EN: negate (saturating) sample_in so absorbance dips become positive pulses.
module ppg_beat_detect
    import ppg_pkg::*;
#(
    parameter int                      AVG_LOG2 = 3,
    parameter int                      DC_SHIFT = 6,
    parameter logic signed [SMP_W-1:0] THRESH   = 24'sd2000,
    parameter int                      REFRACT  = 25,
    parameter int                      IBI_W    = 12,
    parameter int                      IBI_MAX  = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_vld,
    input  logic signed [SMP_W-1:0] sample_in,
    output logic signed [SMP_W-1:0] filt_out,
    output logic                    filt_vld,
    output logic signed [SMP_W-1:0] ac_out,
    output logic                    beat_pulse,
    output logic [IBI_W-1:0]        ibi,
    output logic                    ibi_vld,
    output logic                    no_signal
);
    localparam int BW = SMP_W + DC_SHIFT;
    localparam int RW = $clog2(REFRACT + 1);
    logic signed [SMP_W-1:0] smp, base_int, ac_c, ac_q, ac_d;
    logic signed [BW-1:0] base_q, base_d;
    logic signed [BW:0] diff;
    logic [1:0] st_q, st_d;
    logic [RW-1:0] rc_q, rc_d;
    logic [IBI_W-1:0] cnt_q, cnt_d, ibi_q, ibi_d;
    logic beat, beat_q, beat_d, ibi_vld_q, ibi_vld_d, ns_q, ns_d, fb_q, fb_d;
`ifdef PPG_INVERT_EN
    assign smp = sat(-(SMP_W+1)'(sample_in));
`else
    assign smp = sample_in;
`endif
    ppg_mov_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk       (clk),
        .rst       (rst),
        .smp_vld_i (sample_vld),
        .smp_i     (smp),
        .filt_o    (filt_out),
        .filt_vld_o(filt_vld)
    );
    // Baseline keeps DC_SHIFT fractional bits; AC uses the baseline as it stood before this sample.
    assign diff = ((BW+1)'(filt_out) <<< DC_SHIFT) - (BW+1)'(base_q);
    assign base_d = base_q + BW'(diff >>> DC_SHIFT);
    assign base_int = SMP_W'(base_q >>> DC_SHIFT);
    assign ac_c = sat((SMP_W+1)'(filt_out) - (SMP_W+1)'(base_int));
    assign beat = (st_q == S_PEAK) && (ac_c < THRESH);
    always_comb begin
        st_d = st_q;
        rc_d = rc_q;
        cnt_d = cnt_q;
        ibi_d = ibi_q;
        fb_d = fb_q;
        ns_d = ns_q;
        ac_d = ac_q;
        beat_d = 1'b0;
        ibi_vld_d = 1'b0;
        if (filt_vld) begin
            ac_d = ac_c;
            if (beat) begin
                st_d = S_REFR;
                rc_d = '0;
                cnt_d = '0;
                ns_d = 1'b0;
                fb_d = 1'b0;
                beat_d = 1'b1;
                ibi_vld_d = !fb_q;
                ibi_d = fb_q ? ibi_q : cnt_q + IBI_W'(1);
            end else begin
                cnt_d = (cnt_q == IBI_W'(IBI_MAX)) ? cnt_q : cnt_q + IBI_W'(1);
                st_d = (st_q == S_WAIT && ac_c >= THRESH) ? S_PEAK :
                       (st_q == S_REFR && rc_q == RW'(REFRACT - 1)) ? S_WAIT : st_q;
                rc_d = (st_q == S_REFR) ? rc_q + RW'(1) : rc_q;
                // Only the sample that first reaches saturation restarts detection, so later pulses can still arm.
                if (cnt_q == IBI_W'(IBI_MAX - 1)) begin
                    ns_d = 1'b1;
                    fb_d = 1'b1;
                    st_d = S_WAIT;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
            ac_q <= '0;
            st_q <= S_WAIT;
            rc_q <= '0;
            cnt_q <= '0;
            ibi_q <= '0;
            fb_q <= 1'b1;
            ns_q <= 1'b0;
            beat_q <= 1'b0;
            ibi_vld_q <= 1'b0;
        end else begin
            if (filt_vld) base_q <= base_d;
            ac_q <= ac_d;
            st_q <= st_d;
            rc_q <= rc_d;
            cnt_q <= cnt_d;
            ibi_q <= ibi_d;
            fb_q <= fb_d;
            ns_q <= ns_d;
            beat_q <= beat_d;
            ibi_vld_q <= ibi_vld_d;
        end
    end
    assign ac_out = ac_q;
    assign beat_pulse = beat_q;
    assign ibi = ibi_q;
    assign ibi_vld = ibi_vld_q;
    assign no_signal = ns_q;
endmodule

// File: tb/tb_ppg_beat_detect.sv
// tb_ppg_beat_detect: directed, table-driven self-checking bench for ppg_beat_detect
module tb_ppg_beat_detect;
`ifdef PPG_INVERT_EN
    localparam int SGN = -1;
`else
    localparam int SGN = 1;
`endif
    typedef struct {
        int din;
        int exp_filt;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample_vld = 1'b0;
    logic signed [23:0] sample_in = '0;
    logic signed [23:0] filt_out, ac_out;
    logic filt_vld, beat_pulse, ibi_vld, no_signal;
    logic [11:0] ibi;
    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int ibi_cnt = 0;
    int ibi_log[$];
    vec_t tv[25];
    always #5 clk = ~clk;
    ppg_beat_detect dut (
        .clk       (clk),
        .rst       (rst),
        .sample_vld(sample_vld),
        .sample_in (sample_in),
        .filt_out  (filt_out),
        .filt_vld  (filt_vld),
        .ac_out    (ac_out),
        .beat_pulse(beat_pulse),
        .ibi       (ibi),
        .ibi_vld   (ibi_vld),
        .no_signal (no_signal)
    );
    always @(negedge clk) begin
        if (beat_pulse) beat_cnt++;
        if (ibi_vld) begin
            ibi_cnt++;
            ibi_log.push_back(int'(ibi));
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic push(input int x);
        @(negedge clk);
        sample_vld = 1'b1;
        sample_in = 24'(SGN * x);
    endtask
    task automatic flush();
        @(negedge clk);
        sample_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic pulse(input int gap);
        push(40000);
        repeat (gap - 1) push(0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        sample_vld = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_filt"}, int'(filt_out), 0);
        chk({tag, "_fvld"}, int'(filt_vld), 0);
        chk({tag, "_ac"}, int'(ac_out), 0);
        chk({tag, "_beat"}, int'(beat_pulse), 0);
        chk({tag, "_ibi"}, int'(ibi), 0);
        chk({tag, "_ivld"}, int'(ibi_vld), 0);
        chk({tag, "_nosig"}, int'(no_signal), 0);
    endtask
    initial begin
        int b0, i0, n0;
        for (int i = 0; i < 16; i++) tv[i] = '{8000, (i < 8) ? 1000 * (i + 1) : 8000};
        tv[16] = '{-1, 6999};
        tv[17] = '{-1, 5999};
        tv[18] = '{-1, 4999};
        tv[19] = '{-1, 3999};
        tv[20] = '{-1, 2999};
        tv[21] = '{-1, 1999};
        tv[22] = '{-1, 999};
        tv[23] = '{-1, -1};
        tv[24] = '{-3, -2};
        // reset held from time zero, then quiet input
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        b0 = beat_cnt;
        repeat (10) push(0);
        flush();
        chk("zeros_filt", int'(filt_out), 0);
        chk("zeros_ac", int'(ac_out), 0);
        chk("zeros_beats", beat_cnt - b0, 0);
        // moving-average ramp and floor-shift table, one sample with an idle gap each
        do_reset();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            sample_vld = 1'b1;
            sample_in = 24'(SGN * tv[i].din);
            @(negedge clk);
            sample_vld = 1'b0;
            chk($sformatf("tbl%0d_vld", i), int'(filt_vld), 1);
            chk($sformatf("tbl%0d_filt", i), int'(filt_out), tv[i].exp_filt);
            @(negedge clk);
            chk($sformatf("tbl%0d_vld_off", i), int'(filt_vld), 0);
        end
        // second crossing inside the refractory window is ignored
        do_reset();
        b0 = beat_cnt;
        i0 = ibi_cnt;
        pulse(10);
        pulse(40);
        flush();
        chk("refr_beats", beat_cnt - b0, 1);
        chk("refr_ibis", ibi_cnt - i0, 0);
        // no-signal saturation boundary, then recovery
        do_reset();
        repeat (4094) push(0);
        flush();
        chk("nosig_4094", int'(no_signal), 0);
        push(0);
        flush();
        chk("nosig_4095", int'(no_signal), 1);
        b0 = beat_cnt;
        i0 = ibi_cnt;
        pulse(48);
        flush();
        chk("nosig_b1_beats", beat_cnt - b0, 1);
        chk("nosig_b1_ibis", ibi_cnt - i0, 0);
        chk("nosig_b1_clear", int'(no_signal), 0);
        pulse(48);
        flush();
        chk("nosig_b2_beats", beat_cnt - b0, 2);
        chk("nosig_b2_ibis", ibi_cnt - i0, 1);
        chk("nosig_b2_ibi", int'(ibi), 48);
        // reset in the middle of a pulse
        push(40000);
        repeat (3) push(0);
        @(negedge clk);
        sample_vld = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("midrst");
        rst = 1'b1;
        b0 = beat_cnt;
        i0 = ibi_cnt;
        pulse(48);
        flush();
        chk("midrst_b1_beats", beat_cnt - b0, 1);
        chk("midrst_b1_ibis", ibi_cnt - i0, 0);
        pulse(48);
        flush();
        chk("midrst_b2_ibis", ibi_cnt - i0, 1);
        chk("midrst_b2_ibi", int'(ibi), 48);
        // square wave on a large DC offset: prime the baseline, then 400 samples starting low
        do_reset();
        b0 = beat_cnt;
        i0 = ibi_cnt;
        repeat (600) push(50000);
        flush();
        chk("dc_beats", beat_cnt - b0, 1);
        chk("dc_ibis", ibi_cnt - i0, 0);
        b0 = beat_cnt;
        i0 = ibi_cnt;
        n0 = ibi_log.size();
        for (int i = 0; i < 400; i++) push(((i / 25) % 2 == 0) ? 47000 : 53000);
        flush();
        chk("sq_beats", beat_cnt - b0, 7);
        chk("sq_ibis", ibi_cnt - i0, 7);
        for (int k = 2; k < 7; k++)
            chk($sformatf("sq_ibi%0d", k), (n0 + k < ibi_log.size()) ? ibi_log[n0 + k] : -1, 50);
        // most negative input: passes through, or saturates when inverted
        do_reset();
        @(negedge clk);
        sample_vld = 1'b1;
        sample_in = 24'h800000;
        flush();
`ifdef PPG_INVERT_EN
        chk("minval_filt", int'(filt_out), 1048575);
`else
        chk("minval_filt", int'(filt_out), -1048576);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
